// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU-operation and sequencer-state definitions for the Mini SRC control path.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mini_src_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation selects; register ALU ops use their opcode directly
    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;

    // Sequencer states; the encoding is visible on state_view
    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic ldi;
        logic ld;
        logic st;
        logic nop;
        logic halt;
        logic bad;
    } iclass_t;

    // True for the classes whose T3/T4 compute "Rb + C" (or Rb op C) into Z
    function automatic logic uses_imm(input iclass_t c);
        return c.alu_i | c.ldi | c.ld | c.st;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Opcode to instruction-class decode plus the ALU operation used in T4.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode input.
import mini_src_pkg::*;

module control_decode (
    input  logic [4:0] opcode,
    output iclass_t    iclass,
    output logic [4:0] alu_op
);

    // Classify the opcode and pick the ALU operation for the T4 step
    always_comb begin
        iclass = '0;
        alu_op = OP_NONE;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: begin
                iclass.alu_r = 1'b1;
                alu_op       = opcode;
            end
            OPC_ADDI: begin
                iclass.alu_i = 1'b1;
                alu_op       = OP_ADD;
            end
            OPC_ANDI: begin
                iclass.alu_i = 1'b1;
                alu_op       = OP_AND;
            end
            OPC_ORI: begin
                iclass.alu_i = 1'b1;
                alu_op       = OP_OR;
            end
            // Address / immediate computation is always Rb + C
            OPC_LDI: begin
                iclass.ldi = 1'b1;
                alu_op     = OP_ADD;
            end
            OPC_LD: begin
                iclass.ld = 1'b1;
                alu_op    = OP_ADD;
            end
            OPC_ST: begin
                iclass.st = 1'b1;
                alu_op    = OP_ADD;
            end
            OPC_NOP:  iclass.nop  = 1'b1;
            OPC_HALT: iclass.halt = 1'b1;
            default:  iclass.bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Mini SRC sequencer: fetch T0-T2, decode at T3, per-step datapath strobes.
// Latency: one state per clk; first T0 one cycle after run is seen in RESET.
// Backpressure: none; run only gates leaving RESET, clr always wins.
import mini_src_pkg::*;

module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PC_out,
    output logic        MDR_out,
    output logic        Zlo_out,
    output logic        R_out,
    output logic        C_out,
    output logic        BAout,
    output logic        MAR_rd,
    output logic        MDR_rd,
    output logic        IR_rd,
    output logic        PC_rd,
    output logic        Y_rd,
    output logic        Zlo_rd,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  op_sel,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_view
);

    state_t     state_q;
    state_t     state_d;
    iclass_t    iclass;
    logic [4:0] alu_op;
    logic       halt_bad_q;

    // Only the opcode field matters to the sequencer; register fields go to the datapath
    logic ir_unused;
    assign ir_unused = ^IR[26:0];

    control_decode u_decode (
        .opcode (IR[31:27]),
        .iclass (iclass),
        .alu_op (alu_op)
    );

    // State register; clr returns to RESET from anywhere, including HALT
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember whether HALT was entered through an unsupported opcode
    always_ff @(posedge clk) begin
        if (clr) begin
            halt_bad_q <= 1'b0;
        end else if (state_q == ST_T3) begin
            halt_bad_q <= iclass.bad;
        end
    end

    // Next-state sequencing; instruction length depends on class decoded at T3/T5
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: if (run) state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                if (iclass.halt || iclass.bad) begin
                    state_d = ST_HALT;
                end else if (iclass.nop) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    state_d = (iclass.ld || iclass.st) ? ST_T6 : ST_T0;
            ST_T6:    state_d = ST_T7;
            ST_T7:    state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
    end

    // Per-state control strobe decode; everything not named for a step stays 0
    always_comb begin
        PC_out  = 1'b0;
        MDR_out = 1'b0;
        Zlo_out = 1'b0;
        R_out   = 1'b0;
        C_out   = 1'b0;
        BAout   = 1'b0;
        MAR_rd  = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        PC_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        Rin     = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        op_sel  = OP_NONE;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            // PC -> MAR and PC+1 -> Z; IncPC makes the ALU increment, so op_sel stays 0
            ST_T0: begin
                PC_out = 1'b1;
                MAR_rd = 1'b1;
                IncPC  = 1'b1;
                Zlo_rd = 1'b1;
            end
            ST_T1: begin
                Zlo_out = 1'b1;
                PC_rd   = 1'b1;
                Read    = 1'b1;
                MDR_rd  = 1'b1;
            end
            ST_T2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
            end
            // Rb (or 0 for R0 via BAout) -> Y
            ST_T3: begin
                if (iclass.alu_r) begin
                    Grb   = 1'b1;
                    R_out = 1'b1;
                    Y_rd  = 1'b1;
                end else if (uses_imm(iclass)) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    R_out = 1'b1;
                    Y_rd  = 1'b1;
                end
            end
            // Y op (Rc or C) -> Z
            ST_T4: begin
                if (iclass.alu_r) begin
                    Grc    = 1'b1;
                    R_out  = 1'b1;
                    Zlo_rd = 1'b1;
                    op_sel = alu_op;
                end else if (uses_imm(iclass)) begin
                    C_out  = 1'b1;
                    Zlo_rd = 1'b1;
                    op_sel = alu_op;
                end
            end
            // Result to Ra, or effective address to MAR for memory ops
            ST_T5: begin
                if (iclass.ld || iclass.st) begin
                    Zlo_out = 1'b1;
                    MAR_rd  = 1'b1;
                end else if (iclass.alu_r || iclass.alu_i || iclass.ldi) begin
                    Zlo_out = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            // Load reads memory into MDR; store puts Ra on the bus into MDR
            ST_T6: begin
                if (iclass.ld) begin
                    Read   = 1'b1;
                    MDR_rd = 1'b1;
                end else if (iclass.st) begin
                    Gra    = 1'b1;
                    R_out  = 1'b1;
                    MDR_rd = 1'b1;
                end
            end
            ST_T7: begin
                if (iclass.ld) begin
                    MDR_out = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (iclass.st) begin
                    Write = 1'b1;
                end
            end
            ST_HALT: begin
                halted  = 1'b1;
                illegal = halt_bad_q;
            end
            default: begin
            end
        endcase
    end

    assign state_view = state_q;

endmodule
